// File: rtl/mod_exp_seq.sv
// Sequential modular exponentiation: result = base^exponent mod modulus.
// LSB-first square-and-multiply over a bit-serial interleaved modular multiplier.
module mod_exp_seq #(
    parameter int WIDTH     = 128,
    parameter int EXP_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 ready,
    output logic                 done,
    output logic                 error,
    output logic [WIDTH-1:0]     result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_REDUCE, S_BIT, S_MUL, S_SQR, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [EXP_WIDTH-1:0] e_q;
    logic [WIDTH-1:0]     n_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     x_q;
    logic [WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]     r_q;
    logic [CW-1:0]        cnt_q;
    logic                 error_q;
    logic [WIDTH-1:0]     result_q;

    logic                 last_step;
    logic [WIDTH-1:0]     mul_b;
    logic [WIDTH:0]       dbl, dbl_red, sum, sum_red;
    logic [WIDTH-1:0]     r_next;

    assign last_step = (cnt_q == CW'(WIDTH - 1));

    // One step of the interleaved multiplier: r = 2r + a_bit*b, kept below n.
    assign mul_b   = (state_q == S_REDUCE) ? WIDTH'(1) : x_q;
    assign dbl     = {r_q, 1'b0};
    assign dbl_red = (dbl >= {1'b0, n_q}) ? dbl - {1'b0, n_q} : dbl;
    assign sum     = dbl_red + (a_q[WIDTH-1] ? {1'b0, mul_b} : {(WIDTH+1){1'b0}});
    assign sum_red = (sum >= {1'b0, n_q}) ? sum - {1'b0, n_q} : sum;
    assign r_next  = sum_red[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = (modulus == '0) ? S_DONE : S_REDUCE;
            S_REDUCE: if (last_step) state_d = S_BIT;
            S_BIT: begin
                if (e_q == '0)    state_d = S_DONE;
                else if (e_q[0])  state_d = S_MUL;
                else              state_d = S_SQR;
            end
            S_MUL:    if (last_step) state_d = S_SQR;
            S_SQR:    if (last_step) state_d = S_BIT;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_comb begin
        ready  = (state_q == S_IDLE);
        done   = (state_q == S_DONE);
        error  = error_q;
        result = result_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q      <= '0;
            n_q      <= '0;
            a_q      <= '0;
            x_q      <= '0;
            acc_q    <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            error_q  <= 1'b0;
            result_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                e_q   <= exponent;
                n_q   <= modulus;
                a_q   <= base;
                r_q   <= '0;
                cnt_q <= '0;
                acc_q <= (modulus == WIDTH'(1)) ? WIDTH'(0) : WIDTH'(1);
                if (modulus == '0) begin
                    error_q  <= 1'b1;
                    result_q <= '0;
                end else begin
                    error_q  <= 1'b0;
                end
            end
        end else if (!abort) begin
            case (state_q)
                S_REDUCE, S_MUL, S_SQR: begin
                    if (last_step) begin
                        r_q   <= '0;
                        cnt_q <= '0;
                        if (state_q == S_MUL) begin
                            acc_q <= r_next;
                            a_q   <= x_q;
                        end else begin
                            x_q <= r_next;
                        end
                        if (state_q == S_SQR) e_q <= e_q >> 1;
                    end else begin
                        r_q   <= r_next;
                        a_q   <= a_q << 1;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_BIT: begin
                    // Operand for the coming multiply: acc for MUL, x for SQR.
                    if (e_q == '0)   result_q <= acc_q;
                    else if (e_q[0]) a_q <= acc_q;
                    else             a_q <= x_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_seq.sv
// Bench for mod_exp_seq: directed vectors, error/abort/reset scenarios and
// randomized operations checked against a plain-arithmetic model.
module tb_mod_exp_seq;

    localparam int W  = 16;
    localparam int EW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  base = '0;
    logic [EW-1:0] exponent = '0;
    logic [W-1:0]  modulus = '0;
    logic          ready, done, error;
    logic [W-1:0]  result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_exp_seq #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .base(base), .exponent(exponent), .modulus(modulus),
        .ready(ready), .done(done), .error(error), .result(result)
    );

    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b,
                                                 input logic [EW-1:0] e,
                                                 input logic [W-1:0] n);
        longint unsigned r, x, nn;
        if (n == '0) return '0;
        nn = 64'(n);
        r  = 64'(1) % nn;
        x  = 64'(b) % nn;
        for (int i = 0; i < EW; i++) begin
            if (e[i]) r = (r * x) % nn;
            x = (x * x) % nn;
        end
        return W'(r);
    endfunction

    function automatic int ref_latency(input logic [EW-1:0] e, input logic [W-1:0] n);
        int len;
        if (n == '0) return 1;
        len = 0;
        for (int i = 0; i < EW; i++) if (e[i]) len = i + 1;
        return W + 2 + len * (W + 1) + $countones(e) * W;
    endfunction

    // Waits for ready, issues one start, and follows the run to done.
    task automatic run_op(input logic [W-1:0] b, input logic [EW-1:0] e,
                          input logic [W-1:0] n, output logic [W-1:0] res,
                          output int lat, output logic err, output bit timed_out);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        base = b; exponent = e; modulus = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        timed_out = 1'b0;
        while (!done) begin
            if (lat >= 5000) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        err = error;
        $display("op base=%0d exp=%0d mod=%0d -> result=%0d error=%0b cycle=%0d",
                 b, e, n, res, err, lat);
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || error !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%b done=%b error=%b result=%0d, want 1 0 0 0",
                     ready, done, error, result);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_known;
        logic [W-1:0]  tb_b [6] = '{16'd4, 16'd65, 16'd2790, 16'd1000, 16'd123, 16'd77};
        logic [EW-1:0] tb_e [6] = '{16'd13, 16'd17, 16'd2753, 16'd2, 16'd0, 16'd5};
        logic [W-1:0]  tb_n [6] = '{16'd497, 16'd3233, 16'd3233, 16'd497, 16'd497, 16'd1};
        logic [W-1:0]  tb_r [6] = '{16'd445, 16'd2790, 16'd65, 16'd36, 16'd1, 16'd0};
        int            tb_l [6] = '{134, 0, 0, 0, 18, 0};
        logic [W-1:0]  res;
        int            lat, want_lat;
        logic          err;
        bit            to;
        for (int i = 0; i < 6; i++) begin
            run_op(tb_b[i], tb_e[i], tb_n[i], res, lat, err, to);
            want_lat = (tb_l[i] != 0) ? tb_l[i] : ref_latency(tb_e[i], tb_n[i]);
            checks++;
            if (to || res !== tb_r[i] || err !== 1'b0) begin
                errors++;
                $display("FAIL known_%0d: result=%0d error=%b timeout=%b, want result=%0d error=0",
                         i, res, err, to, tb_r[i]);
            end
            checks++;
            if (lat != want_lat) begin
                errors++;
                $display("FAIL known_latency_%0d: done at cycle %0d, want %0d", i, lat, want_lat);
            end
        end
    endtask

    task automatic test_error;
        logic [W-1:0] res;
        int           lat;
        logic         err;
        bit           to;
        run_op(16'd9, 16'd3, 16'd0, res, lat, err, to);
        checks++;
        if (to || lat != 1 || err !== 1'b1 || res !== '0) begin
            errors++;
            $display("FAIL mod_zero: cycle=%0d error=%b result=%0d, want cycle=1 error=1 result=0",
                     lat, err, res);
        end
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1 || error !== 1'b1) begin
            errors++;
            $display("FAIL mod_zero_after: ready=%b error=%b, want 1 1", ready, error);
        end
        run_op(16'd4, 16'd13, 16'd497, res, lat, err, to);
        checks++;
        if (to || err !== 1'b0 || res !== 16'd445) begin
            errors++;
            $display("FAIL error_clear: error=%b result=%0d, want 0 445", err, res);
        end
    endtask

    task automatic test_abort;
        logic [W-1:0] prev, res;
        int           lat;
        logic         err;
        bit           to, seen;
        prev = result;
        @(negedge clk);
        while (!ready) @(negedge clk);
        base = 16'd4; exponent = 16'd13; modulus = 16'd497; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (49) begin
            @(posedge clk); #1;
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: ready=%b at cycle 50, want 0", ready);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || result !== prev) begin
            errors++;
            $display("FAIL abort_idle: ready=%b done=%b result=%0d, want 1 0 %0d",
                     ready, done, result, prev);
        end
        seen = 1'b0;
        repeat (200) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: done seen=%b, want 0", seen);
        end
        $display("op abort at cycle 50, result held at %0d", result);
        run_op(16'd4, 16'd13, 16'd497, res, lat, err, to);
        checks++;
        if (to || res !== 16'd445 || lat != 134) begin
            errors++;
            $display("FAIL abort_restart: result=%0d cycle=%0d, want 445 134", res, lat);
        end
    endtask

    task automatic test_async_reset;
        logic [W-1:0] res;
        int           lat;
        logic         err;
        bit           to;
        @(negedge clk);
        while (!ready) @(negedge clk);
        base = 16'd65; exponent = 16'd17; modulus = 16'd3233; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (59) begin
            @(posedge clk); #1;
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || error !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL async_reset: ready=%b done=%b error=%b result=%0d, want 1 0 0 0",
                     ready, done, error, result);
        end
        $display("op async reset at cycle 60, result=%0d", result);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(16'd65, 16'd17, 16'd3233, res, lat, err, to);
        checks++;
        if (to || res !== 16'd2790) begin
            errors++;
            $display("FAIL reset_restart: result=%0d, want 2790", res);
        end
    endtask

    task automatic test_ignore_start;
        int  lat, want_lat;
        bit  to;
        want_lat = ref_latency(16'd17, 16'd3233);
        @(negedge clk);
        while (!ready) @(negedge clk);
        base = 16'd65; exponent = 16'd17; modulus = 16'd3233; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        to = 1'b0;
        while (!done) begin
            if (lat >= 5000) begin
                to = 1'b1;
                break;
            end
            if (lat == 20) begin
                base = 16'd4; exponent = 16'd13; modulus = 16'd497; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        $display("op base=65 exp=17 mod=3233 with stray start -> result=%0d cycle=%0d", result, lat);
        checks++;
        if (to || result !== 16'd2790 || lat != want_lat) begin
            errors++;
            $display("FAIL ignore_start: result=%0d cycle=%0d, want 2790 %0d", result, lat, want_lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] res;
        int           lat;
        logic         err;
        bit           to;
        run_op(16'd1000, 16'd2, 16'd497, res, lat, err, to);
        checks++;
        if (to || res !== 16'd36) begin
            errors++;
            $display("FAIL b2b_first: result=%0d, want 36", res);
        end
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: ready=%b after done, want 1", ready);
        end
        run_op(16'd2790, 16'd2753, 16'd3233, res, lat, err, to);
        checks++;
        if (to || res !== 16'd65 || lat != ref_latency(16'd2753, 16'd3233)) begin
            errors++;
            $display("FAIL b2b_second: result=%0d cycle=%0d, want 65 %0d",
                     res, lat, ref_latency(16'd2753, 16'd3233));
        end
    endtask

    task automatic test_random;
        logic [W-1:0]  b, n, res, want;
        logic [EW-1:0] e;
        int            lat, sel;
        logic          err;
        bit            to;
        for (int i = 0; i < 25; i++) begin
            b   = W'($urandom);
            e   = EW'($urandom);
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      n = '0;
            else if (sel == 1) n = W'(1);
            else if (sel == 2) n = W'($urandom_range(2, 31));
            else               n = W'($urandom_range(2, 65535));
            if (i % 5 == 4) e = e >> 10;
            want = ref_modexp(b, e, n);
            run_op(b, e, n, res, lat, err, to);
            checks++;
            if (to || res !== want || err !== (n == '0) || lat != ref_latency(e, n)) begin
                errors++;
                $display("FAIL random_%0d: result=%0d error=%b cycle=%0d, want %0d %b %0d",
                         i, res, err, lat, want, (n == '0), ref_latency(e, n));
            end
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_error();
        test_abort();
        test_async_reset();
        test_ignore_start();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
